restoring_divider: RTL and testbench
====================================

// Module: restoring_divider
// PURPOSE
//   Sequential restoring divider, one quotient bit per clock: Dividend / Divisor -> Quotient, Remainder.
//   Inverse companion of the Booth multiplier; same en/ready window handshake so the ALU sequencer
//   drives both the same way. Multiply output (16b) feeds divide input directly.
// PARAMETERS
//   DW  16  dividend and quotient width
//   VW  8   divisor and remainder width (VW < DW)
// PORTS
//   clk        in   1   single clock, rising edge
//   rst        in   1   synchronous, active-high reset
//   en         in   1   start/hold request, level
//   Dividend   in   DW  numerator, sampled on start edge only
//   Divisor    in   VW  denominator, sampled on start edge only
//   Quotient   out  DW  registered result
//   Remainder  out  VW  registered result
//   ready      out  1   result valid
//   div_zero   out  1   last op had Divisor==0; valid with ready
// BEHAVIOUR
//   Reset: state=IDLE; Quotient=0, Remainder=0, ready=0, div_zero=0, counter=0.
//   rst is honoured in every state, mid-operation included; no result is produced.
//   IDLE: en=1 at edge E0 -> latch operands, clear partial remainder (VW+1 bits) and counter,
//     ready=0, go to BUSY. en=0 -> stay; outputs hold.
//   BUSY, edges E1..E(DW), one step per edge:
//     - shift {P,Q} left one bit;
//     - T = P - {1'b0,Divisor};
//     - if T >= 0: P=T, Q[0]=1; else: P unchanged (restore), Q[0]=0.
//   At E(DW) (E16 by default), with the last step: Quotient/Remainder registered, ready=1, go to DONE.
//     Latency: ready high DW edges after the start edge.
//   Divide by zero: detected at E0. Go to DONE at E1 with Quotient='1, Remainder=Dividend[VW-1:0],
//     div_zero=1, ready=1. No iteration is performed.
//   en=0 during BUSY: abort at that edge -> IDLE, ready stays 0, Quotient/Remainder keep old values.
//   DONE: ready=1 and outputs stable while en=1; the block does not restart while en stays high.
//     When en=0 is seen, the next edge gives IDLE with ready=0; outputs hold their values.
//     A new operation needs en low for at least one edge, then high again.
//   Operand changes after E0 have no effect on the running operation.
// CONFIGURATION
//   DIV_SIGNED_EN defined: two's-complement operands.
//     - Magnitudes are taken at E0 and the same DW-step core runs on them.
//     - Quotient sign = sign(Dividend) XOR sign(Divisor); it truncates toward zero.
//     - Remainder takes the sign of Dividend.
//     - Sign fixup happens on the final edge, so latency is unchanged.
//     - Most-negative / -1: Quotient = 16'h8000, Remainder = 0, no flag.
//     - Divide by zero: same outputs as unsigned.
//   DIV_SIGNED_EN undefined: purely unsigned; no sign logic is synthesised.
// STRUCTURE
//   div_pkg: state encoding (IDLE, BUSY, DONE), default DW/VW localparams, counter width $clog2(DW+1).
//   Sub-module div_step: combinational single restoring step.
//     Inputs: P (VW+1), Q (DW), Divisor (VW). Outputs: next P, next Q.
//   Top holds the FSM, counter, operand and result registers, and the optional sign fixup.
// TESTING
//   1. 16'd129 / 8'd1, en high 20 cycles -> ready at E16; Quotient=129, Remainder=0, div_zero=0.
//   2. 16'd1000 / 8'd7 -> Quotient=142, Remainder=6; 16'd65535 / 8'd255 -> Quotient=257, Remainder=0.
//   3. 16'd500 / 8'd0 -> ready at E1; Quotient=16'hFFFF, Remainder=8'hF4, div_zero=1.
//   4. en dropped at E5 of 1000/7 -> IDLE, ready never rises, outputs unchanged.
//      Restart with en low 1 edge then high -> correct result at E16.
//   5. rst asserted at E8 mid-op -> all outputs 0 next edge; the op after reset completes normally.
//   6. DIV_SIGNED_EN: -100 / 7 -> Quotient=-14, Remainder=-2; 100 / -7 -> Quotient=-14, Remainder=2;
//      16'h8000 / -1 -> Quotient=16'h8000, Remainder=0.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: state encoding, default widths and counter sizing for restoring_divider.
package div_pkg;

   localparam int DW_DEF = 16;
   localparam int VW_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Step counter must be able to hold 0..DW.
   function automatic int cnt_width(input int dw);
      return $clog2(dw + 1);
   endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step on the {P,Q} pair.
module div_step
   import div_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int VW = VW_DEF
) (
   input  logic [VW:0]   p_i,
   input  logic [DW-1:0] q_i,
   input  logic [VW-1:0] divisor_i,
   output logic [VW:0]   p_o,
   output logic [DW-1:0] q_o
);

   logic [VW+1:0] p_sh;
   logic [VW:0]   diff;
   logic          ge;

   // Shift {P,Q} left, trial-subtract the divisor, keep the difference only if it stays non-negative.
   always_comb begin
      p_sh = {p_i, q_i[DW-1]};
      ge   = (p_sh >= {2'b00, divisor_i});
      diff = p_sh[VW:0] - {1'b0, divisor_i};
      p_o  = ge ? diff : p_sh[VW:0];
      q_o  = {q_i[DW-2:0], ge};
   end

endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: sequential restoring divider, one quotient bit per clock.
// en/ready window handshake: start on en rising into IDLE, result held in DONE while en stays high.
// Optional macro DIV_SIGNED_EN: two's-complement operands, magnitude core with sign fixup on the final edge.
module restoring_divider
   import div_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int VW = VW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [DW-1:0] Dividend,
   input  logic [VW-1:0] Divisor,
   output logic [DW-1:0] Quotient,
   output logic [VW-1:0] Remainder,
   output logic          ready,
   output logic          div_zero
);

   localparam int            CW       = cnt_width(DW);
   localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

   state_t        state_q;
   logic [CW-1:0] cnt_q;

   logic [VW:0]   p_q;
   logic [VW:0]   p_d;
   logic [DW-1:0] q_q;
   logic [DW-1:0] q_d;
   logic [VW-1:0] dvs_q;
   logic [VW-1:0] dvd_lo_q;
   logic          dz_q;

   logic [DW-1:0] quot_q;
   logic [VW-1:0] rem_q;
   logic          ready_q;
   logic          div_zero_q;

   logic [DW-1:0] dvd_mag;
   logic [VW-1:0] dvs_mag;
   logic [DW-1:0] quot_fix;
   logic [VW-1:0] rem_fix;

`ifdef DIV_SIGNED_EN
   logic qneg_q;
   logic rneg_q;

   function automatic logic [DW-1:0] abs_dw(input logic signed [DW-1:0] x);
      return x[DW-1] ? -x : x;
   endfunction

   function automatic logic [VW-1:0] abs_vw(input logic signed [VW-1:0] x);
      return x[VW-1] ? -x : x;
   endfunction

   function automatic logic [DW-1:0] neg_dw(input logic neg, input logic [DW-1:0] x);
      return neg ? -x : x;
   endfunction

   function automatic logic [VW-1:0] neg_vw(input logic neg, input logic [VW-1:0] x);
      return neg ? -x : x;
   endfunction

   // Magnitudes feed the core; the final step's result gets the recorded signs back.
   always_comb begin
      dvd_mag  = abs_dw(Dividend);
      dvs_mag  = abs_vw(Divisor);
      quot_fix = neg_dw(qneg_q, q_d);
      rem_fix  = neg_vw(rneg_q, p_d[VW-1:0]);
   end
`else
   // Unsigned build: operands and results pass straight through.
   always_comb begin
      dvd_mag  = Dividend;
      dvs_mag  = Divisor;
      quot_fix = q_d;
      rem_fix  = p_d[VW-1:0];
   end
`endif

   div_step #(
      .DW(DW),
      .VW(VW)
   ) u_step (
      .p_i      (p_q),
      .q_i      (q_q),
      .divisor_i(dvs_q),
      .p_o      (p_d),
      .q_o      (q_d)
   );

   // Operand capture at the start edge, then one restoring step per BUSY edge.
   always_ff @(posedge clk) begin
      if (state_q == ST_IDLE && en) begin
         p_q      <= '0;
         q_q      <= dvd_mag;
         dvs_q    <= dvs_mag;
         dvd_lo_q <= Dividend[VW-1:0];
         dz_q     <= (Divisor == '0);
`ifdef DIV_SIGNED_EN
         qneg_q   <= Dividend[DW-1] ^ Divisor[VW-1];
         rneg_q   <= Dividend[DW-1];
`endif
      end else if (state_q == ST_BUSY) begin
         p_q <= p_d;
         q_q <= q_d;
      end
   end

   // Control FSM with registered results; abort on en low while BUSY, rearm on en low in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         quot_q     <= '0;
         rem_q      <= '0;
         ready_q    <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (en) begin
                  cnt_q   <= '0;
                  ready_q <= 1'b0;
                  state_q <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (!en) begin
                  state_q <= ST_IDLE;
               end else if (dz_q) begin
                  quot_q     <= '1;
                  rem_q      <= dvd_lo_q;
                  div_zero_q <= 1'b1;
                  ready_q    <= 1'b1;
                  state_q    <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
                  if (cnt_q == LAST_CNT) begin
                     quot_q     <= quot_fix;
                     rem_q      <= rem_fix;
                     div_zero_q <= 1'b0;
                     ready_q    <= 1'b1;
                     state_q    <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (!en) begin
                  ready_q <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign Quotient  = quot_q;
   assign Remainder = rem_q;
   assign ready     = ready_q;
   assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: vector table, handshake corner sequences and random ops against an arithmetic model.
module tb_restoring_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] Dividend;
   logic [7:0]  Divisor;
   logic [15:0] Quotient;
   logic [7:0]  Remainder;
   logic        ready;
   logic        div_zero;

   always #5 clk = ~clk;

   restoring_divider #(
      .DW(16),
      .VW(8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .Dividend (Dividend),
      .Divisor  (Divisor),
      .Quotient (Quotient),
      .Remainder(Remainder),
      .ready    (ready),
      .div_zero (div_zero)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  b;
      logic [15:0] q;
      logic [7:0]  r;
      logic        dz;
      int          lat;
   } vec_t;

   localparam int NV = 8;
   vec_t tab[NV];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Reference: plain integer division from the arithmetic definition.
   task automatic model(input logic [15:0] a, input logic [7:0] b,
                        output logic [15:0] q, output logic [7:0] r, output logic dz);
      if (b == 8'd0) begin
         q  = 16'hFFFF;
         r  = a[7:0];
         dz = 1'b1;
      end else begin
`ifdef DIV_SIGNED_EN
         int sa;
         int sb;
         int qi;
         int ri;
         sa = int'($signed(a));
         sb = int'($signed(b));
         qi = sa / sb;
         ri = sa % sb;
         q  = qi[15:0];
         r  = ri[7:0];
`else
         q  = a / {8'd0, b};
         r  = 8'(a % {8'd0, b});
`endif
         dz = 1'b0;
      end
   endtask

   // Start an op, scramble operands after the start edge, count edges until ready (bounded).
   task automatic run_op(input logic [15:0] a, input logic [7:0] b, output int lat);
      @(negedge clk);
      Dividend = a;
      Divisor  = b;
      en       = 1'b1;
      @(posedge clk);
      #1;
      Dividend = 16'($urandom);
      Divisor  = 8'($urandom);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (ready === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   // Check result, hold with en high, then release and check ready drops with outputs held.
   task automatic finish_op(input string tag, input logic [15:0] q, input logic [7:0] r, input logic dz);
      check({tag, "_quot"}, 32'(Quotient), 32'(q));
      check({tag, "_rem"}, 32'(Remainder), 32'(r));
      check({tag, "_dz"}, 32'(div_zero), 32'(dz));
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check({tag, "_hold_ready"}, 32'(ready), 32'd1);
      check({tag, "_hold_quot"}, 32'(Quotient), 32'(q));
      @(negedge clk);
      en = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "_rel_ready"}, 32'(ready), 32'd0);
      check({tag, "_rel_rem"}, 32'(Remainder), 32'(r));
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          lat;
      logic [15:0] mq;
      logic [7:0]  mr;
      logic        mdz;
      logic [15:0] hold_q;
      logic [7:0]  hold_r;

`ifdef DIV_SIGNED_EN
      tab[0] = '{16'hFF9C, 8'd7,   16'hFFF2, 8'hFE, 1'b0, 16};
      tab[1] = '{16'd100,  8'hF9,  16'hFFF2, 8'h02, 1'b0, 16};
      tab[2] = '{16'h8000, 8'hFF,  16'h8000, 8'h00, 1'b0, 16};
      tab[3] = '{16'd500,  8'd0,   16'hFFFF, 8'hF4, 1'b1, 1};
      tab[4] = '{16'hFF9C, 8'd0,   16'hFFFF, 8'h9C, 1'b1, 1};
      tab[5] = '{16'hFC18, 8'hF9,  16'd142,  8'hFA, 1'b0, 16};
      tab[6] = '{16'd129,  8'd1,   16'd129,  8'd0,  1'b0, 16};
      tab[7] = '{16'd1000, 8'd7,   16'd142,  8'd6,  1'b0, 16};
`else
      tab[0] = '{16'd129,   8'd1,   16'd129,   8'd0,   1'b0, 16};
      tab[1] = '{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0, 16};
      tab[2] = '{16'd65535, 8'd255, 16'd257,   8'd0,   1'b0, 16};
      tab[3] = '{16'd500,   8'd0,   16'hFFFF,  8'hF4,  1'b1, 1};
      tab[4] = '{16'd0,     8'd5,   16'd0,     8'd0,   1'b0, 16};
      tab[5] = '{16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0, 16};
      tab[6] = '{16'd100,   8'd255, 16'd0,     8'd100, 1'b0, 16};
      tab[7] = '{16'd12345, 8'd200, 16'd61,    8'd145, 1'b0, 16};
`endif

      rst      = 1'b1;
      en       = 1'b0;
      Dividend = '0;
      Divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_quot", 32'(Quotient), 32'd0);
      check("reset_rem", 32'(Remainder), 32'd0);
      check("reset_ready", 32'(ready), 32'd0);
      check("reset_dz", 32'(div_zero), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Table-driven vectors.
      for (int i = 0; i < NV; i++) begin
         run_op(tab[i].a, tab[i].b, lat);
         check($sformatf("v%0d_latency", i), 32'(lat), 32'(tab[i].lat));
         finish_op($sformatf("v%0d", i), tab[i].q, tab[i].r, tab[i].dz);
      end
      hold_q = tab[NV-1].q;
      hold_r = tab[NV-1].r;

      // Abort: en dropped so that E5 sees it low; ready must never rise, outputs untouched.
      @(negedge clk);
      Dividend = 16'd1000;
      Divisor  = 8'd7;
      en       = 1'b1;
      @(posedge clk);
      repeat (4) @(posedge clk);
      @(negedge clk);
      en = 1'b0;
      @(posedge clk);
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("abort_ready_%0d", k), 32'(ready), 32'd0);
      end
      check("abort_quot", 32'(Quotient), 32'(hold_q));
      check("abort_rem", 32'(Remainder), 32'(hold_r));
      run_op(16'd1000, 8'd7, lat);
      model(16'd1000, 8'd7, mq, mr, mdz);
      check("restart_latency", 32'(lat), 32'd16);
      finish_op("restart", mq, mr, mdz);

      // Synchronous reset seen at E8 of a running op.
      @(negedge clk);
      Dividend = 16'd65535;
      Divisor  = 8'd255;
      en       = 1'b1;
      @(posedge clk);
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      en  = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_quot", 32'(Quotient), 32'd0);
      check("midrst_rem", 32'(Remainder), 32'd0);
      check("midrst_ready", 32'(ready), 32'd0);
      check("midrst_dz", 32'(div_zero), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
      end
      check("midrst_stays_idle", 32'(ready), 32'd0);
      run_op(16'd12345, 8'd200, lat);
      model(16'd12345, 8'd200, mq, mr, mdz);
      check("postrst_latency", 32'(lat), 32'd16);
      finish_op("postrst", mq, mr, mdz);

      // Random operations against the arithmetic model.
      for (int n = 0; n < 150; n++) begin
         logic [15:0] ra;
         logic [7:0]  rb;
         ra = 16'($urandom);
         rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
         model(ra, rb, mq, mr, mdz);
         run_op(ra, rb, lat);
         check($sformatf("rnd%0d_latency_%h_%h", n, ra, rb), 32'(lat), mdz ? 32'd1 : 32'd16);
         finish_op($sformatf("rnd%0d_%h_%h", n, ra, rb), mq, mr, mdz);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
